// File: rtl/fft_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_loader
// Purpose  : Front end of the 8-point single-precision FFT. Collects a serial
//            stream of IEEE-754 samples into 8-sample frames. The frame being
//            written and the frame presented to the FFT sit in separate banks,
//            so frame k+1 can load while the FFT still holds frame k.
//            Sample bits are passed through untouched.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous, active-low reset
//            in_valid   - sample valid
//            in_data    - sample (DW bits)
//            in_sof     - marks in_data as sample 0 of a frame
//            in_ready   - a sample can be accepted this cycle
//            x0..x7     - parallel frame to the FFT
//            out_valid  - x0..x7 hold a complete frame
//            out_ack    - FFT has consumed the frame on x0..x7
//            frame_err  - one-cycle pulse on a framing error
//            frame_cnt  - frames delivered, wraps 255 -> 0
// Options  : FFT_BITREV_EN - when defined, sample n lands in slot bitrev3(n)
//            (decimation-in-time input order); otherwise slot n = sample n.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_loader #(
    parameter int DW  = 32,
    parameter int NPT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_sof,
    output logic          in_ready,
    output logic [DW-1:0] x0,
    output logic [DW-1:0] x1,
    output logic [DW-1:0] x2,
    output logic [DW-1:0] x3,
    output logic [DW-1:0] x4,
    output logic [DW-1:0] x5,
    output logic [DW-1:0] x6,
    output logic [DW-1:0] x7,
    output logic          out_valid,
    input  logic          out_ack,
    output logic          frame_err,
    output logic [7:0]    frame_cnt
);

    localparam int CW = $clog2(NPT);

    // Fill state of the write bank. The output bank's state is out_valid_q.
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    bank_state_t   wstate_q, wstate_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [DW-1:0] wbuf_q [NPT];
    logic [DW-1:0] wbuf_d [NPT];
    logic [DW-1:0] xbuf_q [NPT];
    logic [DW-1:0] xbuf_d [NPT];
    logic          out_valid_q, out_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;

    logic          accept;
    logic          release_out;
    logic          swap;

    // Slot in the bank where sample n is stored; reordering is done on the
    // write side so the swap is a plain bank copy.
    function automatic logic [CW-1:0] slot_of(input logic [CW-1:0] n);
`ifdef FFT_BITREV_EN
        return {n[0], n[1], n[2]};
`else
        return n;
`endif
    endfunction

    assign in_ready    = rst & (wstate_q != BANK_FULL);
    assign accept      = in_valid & in_ready;
    assign release_out = out_valid_q & out_ack;
    // Output bank is free if idle, or being acknowledged on this same edge.
    assign swap        = (wstate_q == BANK_FULL) & (~out_valid_q | out_ack);

    always_comb begin
        wstate_d    = wstate_q;
        wcnt_d      = wcnt_q;
        wbuf_d      = wbuf_q;
        xbuf_d      = xbuf_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (release_out) begin
            out_valid_d = 1'b0;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end

        // Release and swap may share an edge; the swap wins on out_valid.
        if (swap) begin
            xbuf_d      = wbuf_q;
            out_valid_d = 1'b1;
            wstate_d    = BANK_EMPTY;
        end

        // accept requires a non-full write bank, so it never coincides with swap.
        if (accept) begin
            if ((wcnt_q == '0) && !in_sof) begin
                // Orphan sample with no frame start: drop it.
                frame_err_d = 1'b1;
            end else if ((wcnt_q != '0) && in_sof) begin
                // New frame start mid-frame: abandon the partial frame.
                frame_err_d              = 1'b1;
                wbuf_d[slot_of(CW'(0))]  = in_data;
                wcnt_d                   = CW'(1);
                wstate_d                 = BANK_FILLING;
            end else begin
                wbuf_d[slot_of(wcnt_q)] = in_data;
                if (wcnt_q == CW'(NPT - 1)) begin
                    wcnt_d   = '0;
                    wstate_d = BANK_FULL;
                end else begin
                    wcnt_d   = wcnt_q + CW'(1);
                    wstate_d = BANK_FILLING;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wstate_q    <= BANK_EMPTY;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            for (int i = 0; i < NPT; i++) begin
                wbuf_q[i] <= '0;
                xbuf_q[i] <= '0;
            end
        end else begin
            wstate_q    <= wstate_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            wbuf_q      <= wbuf_d;
            xbuf_q      <= xbuf_d;
        end
    end

    assign x0        = xbuf_q[0];
    assign x1        = xbuf_q[1];
    assign x2        = xbuf_q[2];
    assign x3        = xbuf_q[3];
    assign x4        = xbuf_q[4];
    assign x5        = xbuf_q[5];
    assign x6        = xbuf_q[6];
    assign x7        = xbuf_q[7];
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire
